// File: rtl/mdma_ram_arb_ctrl.sv
// mdma_ram_arb_ctrl: single-port-pair RAM front end.
// Clears the 2048x32 RAM after reset, then grants one write and one
// round-robin read per cycle. The read id travels with a valid pipeline
// matched to the RAM read latency.
// Optional feature macro: MDMA_RAM_ECC_CNT_EN enables the saturating
// single/double-bit error counters; without it sbe_cnt/dbe_cnt read 0.
module mdma_ram_arb_ctrl #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        init_done,
    input  logic        wr_req,
    input  logic [10:0] wr_adr,
    input  logic [31:0] wr_dat,
    output logic        wr_gnt,
    input  logic [1:0]  rd_req,
    input  logic [10:0] rd_adr0,
    input  logic [10:0] rd_adr1,
    output logic [1:0]  rd_gnt,
    output logic        rd_vld,
    output logic        rd_id,
    output logic [31:0] rd_dat,
    output logic        rd_sbe,
    output logic        rd_dbe,
    input  logic        clr_cnt,
    output logic [15:0] sbe_cnt,
    output logic [15:0] dbe_cnt,
    output logic [10:0] ram_wadr,
    output logic        ram_wen,
    output logic [31:0] ram_wdat,
    output logic        ram_ren,
    output logic [10:0] ram_radr,
    input  logic [31:0] ram_rdat,
    input  logic        ram_rsbe,
    input  logic        ram_rdbe
);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [10:0]       ptr, ptr_nxt;
    logic              last_gnt;   // 1: requester 1 was granted last
    logic [1:0]        gnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] id_pipe;

    // State, clear pointer and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            ptr      <= '0;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (|gnt)
                last_gnt <= gnt[1];
        end
    end

    // Next state, RAM port muxing and read arbitration
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        init_done = 1'b0;
        wr_gnt    = 1'b0;
        ram_wen   = 1'b0;
        ram_wadr  = '0;
        ram_wdat  = '0;
        gnt       = 2'b00;
        ram_ren   = 1'b0;
        ram_radr  = '0;
        case (state)
            INIT: begin
                // rst gating keeps the write strobe low while reset is held
                ram_wen  = ~rst;
                ram_wadr = ptr;
                ptr_nxt  = ptr + 11'd1;
                if (ptr == 11'h7FF)
                    state_nxt = RUN;
            end
            RUN: begin
                init_done = 1'b1;
                wr_gnt    = wr_req;
                ram_wen   = wr_req;
                ram_wadr  = wr_adr;
                ram_wdat  = wr_dat;
                case (rd_req)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                    default: gnt = 2'b00;
                endcase
                ram_ren  = |gnt;
                ram_radr = gnt[1] ? rd_adr1 : (gnt[0] ? rd_adr0 : 11'd0);
            end
            default: state_nxt = INIT;
        endcase
    end

    assign rd_gnt = gnt;

    generate
        if (RD_LAT == 1) begin : g_pipe1
            // Single-stage valid/id register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe <= '0;
                    id_pipe  <= '0;
                end else begin
                    vld_pipe <= ram_ren;
                    id_pipe  <= gnt[1];
                end
            end
        end else begin : g_pipen
            // Valid/id shift register, one stage per RAM latency cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe <= '0;
                    id_pipe  <= '0;
                end else begin
                    vld_pipe <= {vld_pipe[RD_LAT-2:0], ram_ren};
                    id_pipe  <= {id_pipe[RD_LAT-2:0], gnt[1]};
                end
            end
        end
    endgenerate

    assign rd_vld = vld_pipe[RD_LAT-1];
    assign rd_id  = rd_vld & id_pipe[RD_LAT-1];
    assign rd_dat = rd_vld ? ram_rdat : 32'd0;
    assign rd_sbe = rd_vld & ram_rsbe;
    assign rd_dbe = rd_vld & ram_rdbe;

`ifdef MDMA_RAM_ECC_CNT_EN
    // Saturating error counters; clear has priority over a same-cycle hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else if (clr_cnt) begin
            sbe_cnt <= '0;
            dbe_cnt <= '0;
        end else begin
            if (rd_sbe && sbe_cnt != 16'hFFFF)
                sbe_cnt <= sbe_cnt + 16'd1;
            if (rd_dbe && dbe_cnt != 16'hFFFF)
                dbe_cnt <= dbe_cnt + 16'd1;
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign sbe_cnt    = '0;
    assign dbe_cnt    = '0;
`endif

endmodule

// File: tb/tb_mdma_ram_arb_ctrl.sv
// Bench for mdma_ram_arb_ctrl: behavioural RAM plus a transaction-level
// reference (expected-read queue, reference memory, counter totals).
module tb_mdma_ram_arb_ctrl;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done, wr_req, wr_gnt, rd_vld, rd_id, rd_sbe, rd_dbe, clr_cnt;
    logic [10:0] wr_adr, rd_adr0, rd_adr1, ram_wadr, ram_radr;
    logic [31:0] wr_dat, rd_dat, ram_wdat, ram_rdat;
    logic [1:0]  rd_req, rd_gnt;
    logic [15:0] sbe_cnt, dbe_cnt;
    logic        ram_wen, ram_ren, ram_rsbe, ram_rdbe;

    always #5 clk = ~clk;

    mdma_ram_arb_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .wr_req(wr_req), .wr_adr(wr_adr), .wr_dat(wr_dat), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_adr0(rd_adr0), .rd_adr1(rd_adr1), .rd_gnt(rd_gnt),
        .rd_vld(rd_vld), .rd_id(rd_id), .rd_dat(rd_dat), .rd_sbe(rd_sbe), .rd_dbe(rd_dbe),
        .clr_cnt(clr_cnt), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
        .ram_wadr(ram_wadr), .ram_wen(ram_wen), .ram_wdat(ram_wdat),
        .ram_ren(ram_ren), .ram_radr(ram_radr),
        .ram_rdat(ram_rdat), .ram_rsbe(ram_rsbe), .ram_rdbe(ram_rdbe)
    );

    // Behavioural RAM with RD_LAT-cycle read latency
    logic [31:0] tbmem [0:2047];
    logic [31:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_wen) tbmem[ram_wadr] <= ram_wdat;
        rpipe[0] <= tbmem[ram_radr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdat = rpipe[RD_LAT-1];

    // Reference model state
    typedef struct { longint due; bit id; logic [31:0] dat; } rd_t;
    rd_t         q[$];
    logic [31:0] refmem [0:2047];
    bit          m_init;
    int          m_ptr;
    bit          m_last;
    int          m_sbe, m_dbe;
    longint      cyc = 0;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare one cycle against the model, advance the model, move to next negedge
    task automatic check_cycle();
        bit ev, eid;
        logic [31:0] edat;
        int g;
        rd_t e;
        #1;
        if (rst) begin
            chk("rst_init_done", {31'd0, init_done}, 0);
            chk("rst_ram_wen", {31'd0, ram_wen}, 0);
            chk("rst_ram_ren", {31'd0, ram_ren}, 0);
            chk("rst_rd_gnt", {30'd0, rd_gnt}, 0);
            chk("rst_wr_gnt", {31'd0, wr_gnt}, 0);
            chk("rst_rd_vld", {31'd0, rd_vld}, 0);
            chk("rst_rd_dat", rd_dat, 0);
            chk("rst_sbe_cnt", {16'd0, sbe_cnt}, 0);
            chk("rst_dbe_cnt", {16'd0, dbe_cnt}, 0);
            m_init = 1; m_ptr = 0; m_last = 1; m_sbe = 0; m_dbe = 0;
            q.delete();
        end else begin
            ev = 0; eid = 0; edat = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                ev = 1; eid = q[0].id; edat = q[0].dat;
                void'(q.pop_front());
            end
            chk("rd_vld", {31'd0, rd_vld}, {31'd0, ev});
            chk("rd_id", {31'd0, rd_id}, {31'd0, eid});
            chk("rd_dat", rd_dat, edat);
            chk("rd_sbe", {31'd0, rd_sbe}, {31'd0, ev & ram_rsbe});
            chk("rd_dbe", {31'd0, rd_dbe}, {31'd0, ev & ram_rdbe});
`ifdef MDMA_RAM_ECC_CNT_EN
            chk("sbe_cnt", {16'd0, sbe_cnt}, m_sbe);
            chk("dbe_cnt", {16'd0, dbe_cnt}, m_dbe);
`else
            chk("sbe_cnt_off", {16'd0, sbe_cnt}, 0);
            chk("dbe_cnt_off", {16'd0, dbe_cnt}, 0);
`endif
            if (m_init) begin
                chk("init_done_lo", {31'd0, init_done}, 0);
                chk("init_wen", {31'd0, ram_wen}, 1);
                chk("init_wadr", {21'd0, ram_wadr}, m_ptr);
                chk("init_wdat", ram_wdat, 0);
                chk("init_wr_gnt", {31'd0, wr_gnt}, 0);
                chk("init_rd_gnt", {30'd0, rd_gnt}, 0);
                chk("init_ren", {31'd0, ram_ren}, 0);
                refmem[m_ptr] = 0;
                if (m_ptr == 2047) m_init = 0;
                m_ptr = (m_ptr + 1) % 2048;
            end else begin
                g = -1;
                if (rd_req == 2'b01) g = 0;
                else if (rd_req == 2'b10) g = 1;
                else if (rd_req == 2'b11) g = m_last ? 0 : 1;
                chk("init_done_hi", {31'd0, init_done}, 1);
                chk("wr_gnt", {31'd0, wr_gnt}, {31'd0, wr_req});
                chk("ram_wen", {31'd0, ram_wen}, {31'd0, wr_req});
                if (wr_req) begin
                    chk("ram_wadr", {21'd0, ram_wadr}, {21'd0, wr_adr});
                    chk("ram_wdat", ram_wdat, wr_dat);
                end
                chk("rd_gnt", {30'd0, rd_gnt}, (g < 0) ? 0 : (1 << g));
                chk("ram_ren", {31'd0, ram_ren}, (g >= 0) ? 1 : 0);
                if (g >= 0) begin
                    e.due = cyc + RD_LAT;
                    e.id  = (g == 1);
                    e.dat = refmem[(g == 1) ? rd_adr1 : rd_adr0];
                    chk("ram_radr", {21'd0, ram_radr}, {21'd0, (g == 1) ? rd_adr1 : rd_adr0});
                    q.push_back(e);
                    m_last = (g == 1);
                end
                if (wr_req) refmem[wr_adr] = wr_dat;
            end
            if (clr_cnt) begin
                m_sbe = 0; m_dbe = 0;
            end else begin
                if (ev && ram_rsbe && m_sbe < 65535) m_sbe++;
                if (ev && ram_rdbe && m_dbe < 65535) m_dbe++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        wr_req = 0; wr_adr = 0; wr_dat = 0; rd_req = 0; rd_adr0 = 0; rd_adr1 = 0;
        clr_cnt = 0; ram_rsbe = 0; ram_rdbe = 0;
        @(negedge clk);
        check_cycle();
        check_cycle();

        // Clear sequence with read requests held throughout
        rst = 0; rd_req = 2'b11; rd_adr0 = 11'h010; rd_adr1 = 11'h020;
        repeat (2048) check_cycle();
        // Both requesting for 4 cycles: alternating grants starting with 0
        repeat (4) check_cycle();
        rd_req = 0;
        repeat (RD_LAT + 1) check_cycle();

        // Write then read back the top address via requester 1
        wr_req = 1; wr_adr = 11'h7FF; wr_dat = 32'hDEADBEEF;
        check_cycle();
        wr_req = 0; rd_req = 2'b10; rd_adr1 = 11'h7FF;
        check_cycle();
        rd_req = 0;
        repeat (RD_LAT + 1) check_cycle();

        // Random mix of reads, writes, collisions and error flags
        for (int i = 0; i < 400; i++) begin
            rd_req   = 2'($urandom);
            rd_adr0  = 11'($urandom);
            rd_adr1  = (i % 7 == 0) ? wr_adr : 11'($urandom);
            wr_req   = 1'($urandom);
            wr_adr   = (i % 5 == 0) ? rd_adr0 : 11'($urandom);
            wr_dat   = $urandom;
            ram_rsbe = ($urandom_range(3) == 0);
            ram_rdbe = ($urandom_range(7) == 0);
            clr_cnt  = ($urandom_range(49) == 0);
            check_cycle();
        end
        wr_req = 0; rd_req = 0; ram_rsbe = 0; ram_rdbe = 0; clr_cnt = 0;
        repeat (RD_LAT + 1) check_cycle();

        // Three single-bit beats, one double-bit beat
        clr_cnt = 1; check_cycle(); clr_cnt = 0;
        rd_req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            ram_rsbe = (i >= 3 && i <= 5);
            ram_rdbe = (i == 7);
            check_cycle();
        end
        ram_rsbe = 0; ram_rdbe = 0;
        check_cycle();
        // Clear on the same cycle as a single-bit beat
        clr_cnt = 1; ram_rsbe = 1; check_cycle();
        clr_cnt = 0; ram_rsbe = 0; check_cycle();

        // Saturation: 70000 consecutive error beats
        ram_rsbe = 1; ram_rdbe = 1;
        repeat (70000) check_cycle();
        ram_rsbe = 0; ram_rdbe = 0; rd_req = 0;
        repeat (RD_LAT + 1) check_cycle();

        // Reset one cycle after a grant: read is discarded, clear restarts at 0
        rd_req = 2'b01; rd_adr0 = 11'h123;
        check_cycle();
        rd_req = 0; rst = 1;
        check_cycle();
        check_cycle();
        rst = 0;
        repeat (12) check_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
